// File: rtl/booth_r4_mac_pkg.sv
// Shared types and helpers for the radix-4 Booth MAC: FSM states, Booth digits,
// the triplet recoder and the iteration count.
package mac_pkg;

  typedef enum logic [1:0] {StIdle, StCalc, StAcc, StHold} state_e;

  typedef enum logic [2:0] {DigZero, DigP1, DigP2, DigM1, DigM2} digit_e;

  function automatic int unsigned n_iter(input int unsigned data_width);
    return data_width / 2 + 1;
  endfunction

  // Triplet is {b[2i+1], b[2i], b[2i-1]}
  function automatic digit_e recode(input logic [2:0] triplet);
    digit_e d;
    case (triplet)
      3'b001, 3'b010: d = DigP1;
      3'b011:         d = DigP2;
      3'b100:         d = DigM2;
      3'b101, 3'b110: d = DigM1;
      default:        d = DigZero;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_mac_if.sv
// Operand/result handshake bundle between the operand sequencer, the MAC and the
// result buffer.
interface booth_r4_mac_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  signed_mode;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  acc_out;
  logic                  overflow;
  logic                  busy;

  modport master (
    output in_valid, a, b, signed_mode, acc_clr, out_ready,
    input  in_ready, out_valid, acc_out, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, signed_mode, acc_clr, out_ready,
    output in_ready, out_valid, acc_out, overflow, busy
  );
endinterface

// File: rtl/booth_r4_datapath.sv
// Radix-4 Booth multiplier datapath: operand, partial-product and counter registers.
// One recoded digit is consumed per step; product is valid once the last step retires.
module booth_r4_datapath
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    step,
  input  logic                    signed_mode,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    last
);

  localparam int unsigned ExtW  = DATA_WIDTH + 2;
  localparam int unsigned HighW = DATA_WIDTH + 4;
  localparam int unsigned NIter = n_iter(DATA_WIDTH);
  localparam int unsigned CntW  = $clog2(NIter);

  logic [ExtW-1:0]          m_q;
  logic [ExtW-1:0]          q_q;
  logic                     qm1_q;
  logic signed [HighW-1:0]  h_q;
  logic signed [HighW-1:0]  m_ext;
  logic signed [HighW-1:0]  addend;
  logic signed [HighW-1:0]  h_sum;
  logic [CntW-1:0]          cnt_q;
  digit_e                   digit;

  always_comb begin
    m_ext  = {{2{m_q[ExtW-1]}}, m_q};
    digit  = recode({q_q[1:0], qm1_q});
    addend = '0;
    case (digit)
      DigP1:   addend = m_ext;
      DigP2:   addend = m_ext <<< 1;
      DigM1:   addend = -m_ext;
      DigM2:   addend = -(m_ext <<< 1);
      default: addend = '0;
    endcase
    h_sum = h_q + addend;
  end

  // Extended operands are exact signed values in both modes, so one recoder serves both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      h_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      m_q   <= {{2{signed_mode & a[DATA_WIDTH-1]}}, a};
      q_q   <= {{2{signed_mode & b[DATA_WIDTH-1]}}, b};
      qm1_q <= 1'b0;
      h_q   <= '0;
      cnt_q <= '0;
    end else if (step) begin
      h_q   <= h_sum >>> 2;
      q_q   <= {h_sum[1:0], q_q[ExtW-1:2]};
      qm1_q <= q_q[1];
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign product = {h_q[DATA_WIDTH-3:0], q_q};
  assign last    = (cnt_q == CntW'(NIter - 1));

endmodule

// File: rtl/booth_r4_mac.sv
// Sequential radix-4 Booth multiply-accumulate: FSM, handshakes and the
// accumulate/saturate stage around booth_r4_datapath.
module booth_r4_mac
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 40,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_r4_mac_if.slave bus
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned SumW  = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] MaxPos = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MinNeg = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  logic                 clr_q, sm_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 load, step, last;
  logic [ProdW-1:0]     product;
  logic [SumW-1:0]      prod_ext, base, sum;
  logic                 ovf_op;

  booth_r4_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .signed_mode (bus.signed_mode),
    .a           (bus.a),
    .b           (bus.b),
    .product     (product),
    .last        (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step = 1'b1;
        if (last) state_d = StAcc;
      end
      StAcc:  state_d = StHold;
      StHold: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // One guard bit above the accumulator exposes signed overflow as a top-bit mismatch
  always_comb begin
    prod_ext = {{(SumW-ProdW){sm_q & product[ProdW-1]}}, product};
    base     = clr_q ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
    sum      = base + prod_ext;
    ovf_op   = sum[SumW-1] ^ sum[SumW-2];
    acc_d    = sum[ACC_WIDTH-1:0];
    if (ovf_op && SATURATE) acc_d = sum[SumW-1] ? MinNeg : MaxPos;
    ovf_d    = (ovf_q & ~clr_q) | ovf_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      clr_q   <= 1'b0;
      sm_q    <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        clr_q <= bus.acc_clr;
        sm_q  <= bus.signed_mode;
      end
      if (state_q == StAcc) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StHold);
  assign bus.busy      = (state_q != StIdle);
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_booth_r4_mac.sv
// Directed bench for booth_r4_mac: a 40-bit instance plus 32-bit saturating and
// wrapping instances, all driven in lockstep from one stimulus stream.
module tb_booth_r4_mac;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        signed_mode, acc_clr, out_ready;

  booth_r4_mac_if #(.DATA_WIDTH(16), .ACC_WIDTH(40)) bus40 ();
  booth_r4_mac_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus_s ();
  booth_r4_mac_if #(.DATA_WIDTH(16), .ACC_WIDTH(32)) bus_w ();

  assign bus40.in_valid = in_valid;
  assign bus40.a = a;
  assign bus40.b = b;
  assign bus40.signed_mode = signed_mode;
  assign bus40.acc_clr = acc_clr;
  assign bus40.out_ready = out_ready;
  assign bus_s.in_valid = in_valid;
  assign bus_s.a = a;
  assign bus_s.b = b;
  assign bus_s.signed_mode = signed_mode;
  assign bus_s.acc_clr = acc_clr;
  assign bus_s.out_ready = out_ready;
  assign bus_w.in_valid = in_valid;
  assign bus_w.a = a;
  assign bus_w.b = b;
  assign bus_w.signed_mode = signed_mode;
  assign bus_w.acc_clr = acc_clr;
  assign bus_w.out_ready = out_ready;

  booth_r4_mac #(.DATA_WIDTH(16), .ACC_WIDTH(40), .SATURATE(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus40)
  );

  booth_r4_mac #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  booth_r4_mac #(.DATA_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic        clr;
    logic [39:0] e40;
    logic        o40;
    logic [31:0] es;
    logic        os;
    logic [31:0] ew;
    logic        ow;
  } vec_t;

  vec_t vecs[15];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Issue one operation and return edges from accept to out_valid (40 = timed out)
  task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vsm,
                       input logic vclr, output int lat);
    @(negedge clk);
    a = va; b = vb; signed_mode = vsm; acc_clr = vclr; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!bus40.out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [39:0] held;

    //              a        b        sm    clr   acc40           o40   sat32          os    wrap32         ow
    vecs[0]  = '{16'h8000, 16'h8000, 1'b1, 1'b1, 40'h0040000000, 1'b0, 32'h40000000, 1'b0, 32'h40000000, 1'b0};
    vecs[1]  = '{16'h8000, 16'h8000, 1'b1, 1'b0, 40'h0080000000, 1'b0, 32'h7FFFFFFF, 1'b1, 32'h80000000, 1'b1};
    vecs[2]  = '{16'h0001, 16'h0001, 1'b1, 1'b1, 40'h0000000001, 1'b0, 32'h00000001, 1'b0, 32'h00000001, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 40'h00FFFE0001, 1'b0, 32'h7FFFFFFF, 1'b1, 32'hFFFE0001, 1'b1};
    vecs[4]  = '{16'h0003, 16'hFFFB, 1'b1, 1'b1, 40'hFFFFFFFFF1, 1'b0, 32'hFFFFFFF1, 1'b0, 32'hFFFFFFF1, 1'b0};
    vecs[5]  = '{16'h0007, 16'h0006, 1'b1, 1'b0, 40'h000000001B, 1'b0, 32'h0000001B, 1'b0, 32'h0000001B, 1'b0};
    vecs[6]  = '{16'hFFFE, 16'hFFFE, 1'b1, 1'b0, 40'h000000001F, 1'b0, 32'h0000001F, 1'b0, 32'h0000001F, 1'b0};
    vecs[7]  = '{16'h8000, 16'h0002, 1'b0, 1'b1, 40'h0000010000, 1'b0, 32'h00010000, 1'b0, 32'h00010000, 1'b0};
    vecs[8]  = '{16'h1234, 16'h5678, 1'b0, 1'b1, 40'h0006260060, 1'b0, 32'h06260060, 1'b0, 32'h06260060, 1'b0};
    vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 40'h0006260061, 1'b0, 32'h06260061, 1'b0, 32'h06260061, 1'b0};
    vecs[10] = '{16'h8000, 16'h7FFF, 1'b1, 1'b1, 40'hFFC0008000, 1'b0, 32'hC0008000, 1'b0, 32'hC0008000, 1'b0};
    vecs[11] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 40'hFF80010000, 1'b0, 32'h80010000, 1'b0, 32'h80010000, 1'b0};
    vecs[12] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 40'hFF40018000, 1'b0, 32'h80000000, 1'b1, 32'h40018000, 1'b1};
    vecs[13] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 40'h003FFF0001, 1'b0, 32'h3FFF0001, 1'b0, 32'h3FFF0001, 1'b0};
    vecs[14] = '{16'h8000, 16'hFFFF, 1'b0, 1'b1, 40'h007FFF8000, 1'b0, 32'h7FFF8000, 1'b0, 32'h7FFF8000, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", {63'(bus40.acc_out), bus40.overflow},                 64'h0);
    check("reset flags", {bus40.in_ready, bus40.out_valid, bus40.busy},        64'h4);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset flags", {bus40.in_ready, bus40.out_valid, bus40.busy},   64'h4);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].clr, lat);
      check($sformatf("v%0d latency", i), 64'(lat),              64'd10);
      check($sformatf("v%0d acc40", i),   64'(bus40.acc_out),    64'(vecs[i].e40));
      check($sformatf("v%0d ovf40", i),   64'(bus40.overflow),   64'(vecs[i].o40));
      check($sformatf("v%0d acc_sat", i), 64'(bus_s.acc_out),    64'(vecs[i].es));
      check($sformatf("v%0d ovf_sat", i), 64'(bus_s.overflow),   64'(vecs[i].os));
      check($sformatf("v%0d acc_wrap", i), 64'(bus_w.acc_out),   64'(vecs[i].ew));
      check($sformatf("v%0d ovf_wrap", i), 64'(bus_w.overflow),  64'(vecs[i].ow));
      take_result();
    end

    // Saturating accumulator with sticky overflow, then reset mid-CALC
    issue(16'h8000, 16'h8000, 1'b1, 1'b1, lat);
    take_result();
    issue(16'h8000, 16'h8000, 1'b1, 1'b0, lat);
    take_result();
    check("pre-reset sat ovf", 64'(bus_s.overflow), 64'h1);
    @(negedge clk);
    a = 16'h0005; b = 16'h0005; signed_mode = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst acc40",    64'(bus40.acc_out), 64'h0);
    check("rst acc_sat",  64'(bus_s.acc_out), 64'h0);
    check("rst ovf_sat",  64'(bus_s.overflow), 64'h0);
    check("rst flags",    {bus40.in_ready, bus40.out_valid, bus40.busy}, 64'h4);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h5678, 1'b0, 1'b0, lat);
    check("after-rst latency", 64'(lat),            64'd10);
    check("after-rst acc40",   64'(bus40.acc_out),  64'h0006260060);
    check("after-rst acc_sat", 64'(bus_s.acc_out),  64'h06260060);
    check("after-rst ovf_sat", 64'(bus_s.overflow), 64'h0);
    take_result();

    // Backpressure: result held while a new request waits
    issue(16'h0003, 16'hFFFB, 1'b1, 1'b1, lat);
    held = bus40.acc_out;
    check("bp initial", 64'(held), 64'hFFFFFFFFF1);
    @(negedge clk);
    a = 16'h0100; b = 16'h0100; signed_mode = 1'b0; acc_clr = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp cycle %0d", i),
            {22'h0, bus40.out_valid, bus40.in_ready, bus40.acc_out},
            {22'h0, 1'b1, 1'b0, 40'hFFFFFFFFF1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    take_result();
    repeat (3) @(posedge clk);
    #1;
    check("bp idle flags", {bus40.in_ready, bus40.out_valid, bus40.busy}, 64'h4);
    check("bp no new op",  64'(bus40.acc_out), 64'hFFFFFFFFF1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/booth_r4_mac.md
Name: booth_r4_mac

Overview:
Sequential radix-4 Booth multiply-accumulate unit. It is the parametrised successor to the radix-2 Booth FSM/datapath plus 40-bit adder, and adds:
- selectable signed/unsigned operands
- valid/ready handshakes on input and output
- accumulator clear-on-issue
- optional saturation with a sticky overflow flag

It sits between the operand sequencer and the result buffer of the MAC pipeline.

Parameters:
DATA_WIDTH, 16, operand width; must be even and >= 4.
ACC_WIDTH, 40, accumulator width; must be >= 2*DATA_WIDTH.
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operands a, b, signed_mode, acc_clr are valid
in_ready  out  1  unit can accept an operation
a  in  DATA_WIDTH  multiplicand
b  in  DATA_WIDTH  multiplier
signed_mode  in  1  1 = both operands two's complement, 0 = both unsigned
acc_clr  in  1  1 = this operation starts a fresh accumulation (acc = product)
out_valid  out  1  acc_out holds the result of the last accepted operation
out_ready  in  1  consumer takes the result
acc_out  out  ACC_WIDTH  accumulator register, signed
overflow  out  1  sticky overflow flag
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: clk is the clock. rst_n is an asynchronous, active-low reset.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; acc_out = 0; overflow = 0; busy = 0; all internal registers = 0.
- Reset mid-operation: aborts immediately with the same values; the in-flight operation is lost.
- Derived constants:
  - N_ITER = DATA_WIDTH/2 + 1.
  - Operands are extended to DATA_WIDTH+2 bits: sign extension if signed_mode, zero extension otherwise.
- States IDLE, CALC, ACC, HOLD:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture the extended operands, acc_clr and signed_mode; clear the partial product and iteration counter; go to CALC.
  - CALC: one radix-4 step per cycle, for exactly N_ITER cycles.
    - Recode the triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1] = 0, to a digit in {0, ±M, ±2M}.
    - Add the digit to the high part, then arithmetic-shift right by 2.
    - After the last iteration go to ACC.
    - The product is exactly 2*DATA_WIDTH bits: signed in signed_mode, unsigned (zero-extended) otherwise.
  - ACC: single cycle.
    - sum = (acc_clr ? 0 : acc_out) + extend(product). The product is sign-extended if signed_mode, else zero-extended to ACC_WIDTH. The sum is computed at ACC_WIDTH+1 bits.
    - Overflow is detected when the top two bits of the ACC_WIDTH+1-bit sum differ.
    - If overflow and SATURATE = 1: acc_out = most-positive or most-negative value per the sum sign.
    - If overflow and SATURATE = 0: acc_out takes the low ACC_WIDTH bits.
    - overflow <= (acc_clr ? 0 : overflow) | ovf_this_op.
    - Go to HOLD.
  - HOLD: out_valid = 1; acc_out and overflow are stable. When out_ready is high, go to IDLE in the next cycle. out_valid may stay high indefinitely (backpressure).
- Latency:
  - The accept edge is cycle 0. out_valid rises N_ITER+1 edges later (10 for DATA_WIDTH = 16).
  - Minimum issue interval is N_ITER+3 cycles.
- Handshake rules:
  - in_ready is low in CALC, ACC and HOLD; operands presented then are ignored and must be held by the source.
  - No input is accepted in the same cycle as an out_ready handshake; IDLE must be entered first.
- Width rules: the extreme operand -2^(DATA_WIDTH-1) in either position must give the exact product.
- Unsigned operands always use the zero-extended recoding, so all-ones operands are exact.

Decomposition:
- Package mac_pkg holds:
  - the state enum (IDLE, CALC, ACC, HOLD)
  - the Booth digit enum (ZERO, P1, P2, M1, M2)
  - a recode function that maps a 3-bit triplet to a digit
  - the function n_iter(DATA_WIDTH)
- One sub-module, booth_r4_datapath: holds the operand, partial-product and counter registers and produces the product. The top level keeps the FSM, handshakes and accumulate/saturate stage.

Test Plan:
- Signed extreme: signed_mode = 1, acc_clr = 1, a = b = 0x8000 -> acc_out = 0x0040000000, overflow = 0, out_valid exactly 10 cycles after accept.
- Unsigned extreme: signed_mode = 0, acc_clr = 1, a = b = 0xFFFF -> acc_out = 0x00FFFE0001.
- Accumulate with clear: ops (3 × -5, clr), (7 × 6), (-2 × -2) -> acc_out sequence 0xFFFFFFFFF1 (-15), 0x000000001B (27), 0x000000001F (31).
- Saturation (ACC_WIDTH = 32, SATURATE = 1): 0x8000 × 0x8000 signed, clr, then the same without clr -> 0x40000000 then 0x7FFFFFFF with overflow = 1. A following clr op 1 × 1 -> acc_out = 1, overflow = 0.
- Wrap (ACC_WIDTH = 32, SATURATE = 0): the same two-op sequence -> 0x80000000, overflow = 1.
- Backpressure and reset:
  - Hold out_ready = 0 for 20 cycles with in_valid high -> out_valid and acc_out stable, in_ready = 0, no new op accepted.
  - Assert rst_n low mid-CALC -> all outputs at reset values the same cycle; the next op runs correctly.
